// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared button channel indices and debounce channel state encoding
package player_pkg;

    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_FIRE = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } chan_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: 2-flop synchronizer, stable-count debounce, press/release/repeat pulses
module debounce_channel
    import player_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic          sync1_q, sync2_q;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // The repeat counter is only touched in HELD, so a bounce into RELEASE_WAIT freezes it.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_HELD;
                    db_cnt_d  = '0;
                    press_d   = 1'b1;
                    rpt_cnt_d = RPT_DELAY;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = ONE;
                end else if (REPEAT_EN) begin
                    if (rpt_cnt_q == ONE) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = RPT_PERIOD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d  = ST_HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, synchronized push-button front end feeding player_controller
module button_conditioner
    import player_pkg::*;
#(
    parameter int                   N_BUTTONS       = 3,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   REPEAT_DELAY    = 8,
    parameter int                   REPEAT_PERIOD   = 4,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 3'b011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_chan (
            .clk_i    (clk),
            .rst_i    (rst),
            .raw_i    (btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

endmodule
